dma_write_engine: RTL and testbench
===================================

DMA_WRITE_ENGINE -- requirements
Module: dma_write_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the SRAM word-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, fixed at 2, the number of beat-buffer entries.
REQ-003 SHALL use one clock and a synchronous, active-low reset: port clk is the clock and port rst is the reset, and rst=0 at a rising edge resets the block.
REQ-004 SHALL provide these ports, each with name, direction, width and meaning:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- start  in  1  one-cycle launch pulse
- cfg_index  in  32  DMA destination index
- cfg_beats  in  16  transfer length in 64-bit beats
- cfg_sram_base  in  ADDR_W  first SRAM word address
- sram_addr0  out  ADDR_W  SRAM port-0 read address (even words)
- sram_addr1  out  ADDR_W  SRAM port-1 read address (odd words)
- sram_rdata0  in  32  SRAM port-0 data
- sram_rdata1  in  32  SRAM port-1 data
- dma_write_ctrl_valid  out  1  control request valid
- dma_write_ctrl_ready  in  1  control request accepted
- dma_write_ctrl_data_index  out  32  destination index
- dma_write_ctrl_data_length  out  32  number of beats
- dma_write_ctrl_data_size  out  3  word size code
- dma_write_chnl_valid  out  1  data beat valid
- dma_write_chnl_ready  in  1  data beat accepted
- dma_write_chnl_data  out  64  data beat
- write_done  out  1  one-cycle completion pulse

Function
REQ-005 SHALL implement states IDLE, CTRL, XFER and DONE.
REQ-006 SHALL, in IDLE on start=1, latch cfg_index, cfg_beats and cfg_sram_base, then go to CTRL; if cfg_beats=0 it SHALL go to DONE instead and perform no DMA handshakes.
REQ-007 SHALL, in CTRL, hold dma_write_ctrl_valid=1 with index=latched cfg_index, length={16'b0, cfg_beats} and size=3'b010, keeping all fields stable until valid&ready.
REQ-008 SHALL treat valid&ready high in cycle N as the control handshake: dma_write_ctrl_valid SHALL be 0 from cycle N+1, and the state SHALL be XFER from cycle N+1.
REQ-009 SHALL form beat k (0-based) as {word at base+2k+1, word at base+2k}; sram_addr0 SHALL equal base+2k and sram_addr1 SHALL equal base+2k+1, both computed modulo 2^ADDR_W.
REQ-010 SHALL present SRAM addresses combinationally from a read pointer; the SRAM samples them at the rising edge, rdata is valid in the following cycle, and the block SHALL push {sram_rdata1, sram_rdata0} into the FIFO at the end of that cycle.
REQ-011 SHALL issue a read in XFER only when reads issued < beats and (FIFO occupancy + in-flight reads − beat accepted this cycle) ≤ 1, so the FIFO never overflows.
REQ-012 SHALL drive dma_write_chnl_valid = FIFO not empty and dma_write_chnl_data = FIFO head, and SHALL pop the head on valid&ready.
REQ-013 SHALL hold data stable while valid=1 and ready=0.
REQ-014 SHALL, with the handshake in cycle N and ready held high, assert the first chnl_valid in cycle N+3, sustain one beat per cycle, and accept the last beat in cycle N+2+beats.
REQ-015 SHALL go to DONE in the cycle after the beat-accepted count reaches cfg_beats.
REQ-016 SHALL assert write_done=1 for exactly one cycle in DONE and then return to IDLE.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL leave sram_addr0/1 at 0 when no read is being issued.
REQ-019 SHALL use a 16-bit beat counter; cfg_beats=65535 SHALL complete without wrap.

Reset
REQ-020 SHALL, on rst=0, set the state to IDLE and drive to 0: all valid outputs, ctrl data fields, chnl data, write_done, the counters, FIFO occupancy and the in-flight flags.
REQ-021 SHALL, on reset in any state, abort the transfer within that edge, discarding buffered beats, with no further handshakes until the next start.

Verification
REQ-022 SHALL pass this scenario: base=0, beats=4, index=0x100, ctrl_ready=1 in the first CTRL cycle, chnl_ready=1 -> one ctrl transfer (index 0x100, length 4, size 2), beats {w1,w0},{w3,w2},{w5,w4},{w7,w6} on consecutive cycles, and write_done 1 cycle after the last beat.
REQ-023 SHALL pass this scenario: ctrl_ready held 0 for 5 cycles -> ctrl_valid and fields stable for 5 cycles, and no SRAM read before the handshake.
REQ-024 SHALL pass this scenario: beats=8 with chnl_ready toggling 1,0,0,1,... -> data stable while stalled, all 8 beats delivered in order with none lost or duplicated, and the FIFO never exceeding 2 entries.
REQ-025 SHALL pass this scenario: cfg_beats=0 -> no ctrl_valid, and write_done in the cycle after start.
REQ-026 SHALL pass this scenario: rst=0 asserted after beat 2 of 8 -> all outputs 0 on the next cycle, and a fresh start with beats=2 completes normally.
REQ-027 SHALL pass this scenario: base=0xFFFE, beats=2 -> addresses 0xFFFE/0xFFFF, then 0x0000/0x0001.

Source files
------------

// File: rtl/dma_write_engine.sv
// DMA write engine.
// Reads 64-bit beats from a dual-port SRAM as word pairs and streams them to
// a DMA write channel after issuing one control request. A two-entry beat
// FIFO absorbs the one-cycle SRAM read latency and downstream back-pressure.
module dma_write_engine #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       cfg_index,
  input  logic [15:0]       cfg_beats,
  input  logic [ADDR_W-1:0] cfg_sram_base,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [ADDR_W-1:0] sram_addr1,
  input  logic [31:0]       sram_rdata0,
  input  logic [31:0]       sram_rdata1,
  output logic              dma_write_ctrl_valid,
  input  logic              dma_write_ctrl_ready,
  output logic [31:0]       dma_write_ctrl_data_index,
  output logic [31:0]       dma_write_ctrl_data_length,
  output logic [2:0]        dma_write_ctrl_data_size,
  output logic              dma_write_chnl_valid,
  input  logic              dma_write_chnl_ready,
  output logic [63:0]       dma_write_chnl_data,
  output logic              write_done
);

  // FIFO pointers wrap naturally, so the depth must stay a power of two.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, CTRL, XFER, DONE} state_e;

  state_e            state_q, state_d;
  logic [31:0]       index_q, index_d;
  logic [15:0]       beats_q, beats_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]       issued_q, issued_d;
  logic [15:0]       accepted_q, accepted_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  logic              write_done_q, write_done_d;
  logic              inflight_q, inflight_d;
  logic [63:0]       fifo_q [FIFO_DEPTH];
  logic [63:0]       fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_idx_q, rd_idx_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic ctrl_hs;
  logic chnl_valid;
  logic chnl_accept;
  logic room_ok;
  logic issue;
  logic push;

  // Handshakes, read-issue throttle and combinational SRAM addressing.
  always_comb begin
    ctrl_hs     = ctrl_valid_q && dma_write_ctrl_ready;
    chnl_valid  = (occ_q != '0);
    chnl_accept = chnl_valid && dma_write_chnl_ready;
    // A new read may land only if, counting the read already in flight and
    // the beat leaving this cycle, one FIFO slot is still free for it.
    room_ok     = (int'(occ_q) + int'(inflight_q)) <= (FIFO_DEPTH - 1 + int'(chnl_accept));
    issue       = (state_q == XFER) && (issued_q < beats_q) && room_ok;
    push        = inflight_q;
    sram_addr0  = issue ? rd_ptr_q : '0;
    sram_addr1  = issue ? (rd_ptr_q + ADDR_W'(1)) : '0;
  end

  // Next-state logic for the FSM, counters, read pointer and beat FIFO.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned
    // and infers a latch.
    state_d      = state_q;
    index_d      = index_q;
    beats_d      = beats_q;
    size_d       = size_q;
    rd_ptr_d     = rd_ptr_q;
    issued_d     = issued_q;
    accepted_d   = accepted_q;
    ctrl_valid_d = ctrl_valid_q;
    write_done_d = 1'b0;
    inflight_d   = issue;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_idx_d     = rd_idx_q;
    occ_d        = occ_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          index_d    = cfg_index;
          beats_d    = cfg_beats;
          size_d     = 3'b010;
          rd_ptr_d   = cfg_sram_base;
          issued_d   = '0;
          accepted_d = '0;
          if (cfg_beats == 16'd0) begin
            state_d      = DONE;
            write_done_d = 1'b1;
          end else begin
            state_d      = CTRL;
            ctrl_valid_d = 1'b1;
          end
        end
      end
      CTRL: begin
        if (ctrl_hs) begin
          ctrl_valid_d = 1'b0;
          state_d      = XFER;
        end
      end
      XFER: begin
        if (chnl_accept && (accepted_q + 16'd1 == beats_q)) begin
          state_d      = DONE;
          write_done_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      issued_d = issued_q + 16'd1;
      rd_ptr_d = rd_ptr_q + ADDR_W'(2);
    end

    if (chnl_accept) begin
      accepted_d = accepted_q + 16'd1;
      rd_idx_d   = rd_idx_q + PTR_W'(1);
    end

    if (push) begin
      fifo_d[wr_ptr_q] = {sram_rdata1, sram_rdata0};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    occ_d = occ_q + OCC_W'(push) - OCC_W'(chnl_accept);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      state_q      <= IDLE;
      index_q      <= '0;
      beats_q      <= '0;
      size_q       <= '0;
      rd_ptr_q     <= '0;
      issued_q     <= '0;
      accepted_q   <= '0;
      ctrl_valid_q <= 1'b0;
      write_done_q <= 1'b0;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_idx_q     <= '0;
      occ_q        <= '0;
      // NOTE: the beat storage is reset too; it is only two entries and the
      // channel data output must read 0 straight out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      beats_q      <= beats_d;
      size_q       <= size_d;
      rd_ptr_q     <= rd_ptr_d;
      issued_q     <= issued_d;
      accepted_q   <= accepted_d;
      ctrl_valid_q <= ctrl_valid_d;
      write_done_q <= write_done_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_idx_q     <= rd_idx_d;
      occ_q        <= occ_d;
      fifo_q       <= fifo_d;
    end
  end

  assign dma_write_ctrl_valid       = ctrl_valid_q;
  assign dma_write_ctrl_data_index  = index_q;
  assign dma_write_ctrl_data_length = {16'b0, beats_q};
  assign dma_write_ctrl_data_size   = size_q;
  assign dma_write_chnl_valid       = chnl_valid;
  assign dma_write_chnl_data        = fifo_q[rd_idx_q];
  assign write_done                 = write_done_q;

endmodule

// File: tb/tb_dma_write_engine.sv
// Directed bench for dma_write_engine: a registered SRAM model plus a
// negedge monitor that logs handshakes, accepted beats and done pulses.
module tb_dma_write_engine;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [31:0]       cfg_index;
  logic [15:0]       cfg_beats;
  logic [ADDR_W-1:0] cfg_sram_base;
  logic [ADDR_W-1:0] sram_addr0, sram_addr1;
  logic [31:0]       sram_rdata0, sram_rdata1;
  logic              dma_write_ctrl_valid, dma_write_ctrl_ready;
  logic [31:0]       dma_write_ctrl_data_index, dma_write_ctrl_data_length;
  logic [2:0]        dma_write_ctrl_data_size;
  logic              dma_write_chnl_valid, dma_write_chnl_ready;
  logic [63:0]       dma_write_chnl_data;
  logic              write_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  dma_write_engine #(.ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .start                      (start),
    .cfg_index                  (cfg_index),
    .cfg_beats                  (cfg_beats),
    .cfg_sram_base              (cfg_sram_base),
    .sram_addr0                 (sram_addr0),
    .sram_addr1                 (sram_addr1),
    .sram_rdata0                (sram_rdata0),
    .sram_rdata1                (sram_rdata1),
    .dma_write_ctrl_valid       (dma_write_ctrl_valid),
    .dma_write_ctrl_ready       (dma_write_ctrl_ready),
    .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
    .dma_write_chnl_valid       (dma_write_chnl_valid),
    .dma_write_chnl_ready       (dma_write_chnl_ready),
    .dma_write_chnl_data        (dma_write_chnl_data),
    .write_done                 (write_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM contents are a fixed function of the word address.
  function automatic logic [31:0] word(input logic [ADDR_W-1:0] a);
    return {16'hA5A5 ^ a, a};
  endfunction

  function automatic logic [63:0] exp_beat(input logic [ADDR_W-1:0] base, input int k);
    logic [ADDR_W-1:0] a0;
    a0 = base + ADDR_W'(2 * k);
    return {word(a0 + ADDR_W'(1)), word(a0)};
  endfunction

  // Registered-read SRAM: data for an address sampled at an edge appears
  // during the following cycle.
  always @(posedge clk) begin
    sram_rdata0 <= word(sram_addr0);
    sram_rdata1 <= word(sram_addr1);
  end

  // Monitor log, written only here.
  int          hs_cyc_q[$];
  logic [31:0] hs_idx_q[$];
  logic [31:0] hs_len_q[$];
  logic [2:0]  hs_size_q[$];
  logic [63:0] beat_q[$];
  int          beat_cyc_q[$];
  int          done_cyc_q[$];
  int          ctrl_valid_cycles = 0;
  int          stall_seen = 0;
  int          stall_bad = 0;
  int          max_occ = 0;
  logic        stall_prev = 1'b0;
  logic [63:0] stall_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (dma_write_ctrl_valid) ctrl_valid_cycles++;
      if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
        hs_cyc_q.push_back(cyc);
        hs_idx_q.push_back(dma_write_ctrl_data_index);
        hs_len_q.push_back(dma_write_ctrl_data_length);
        hs_size_q.push_back(dma_write_ctrl_data_size);
      end
      if (dma_write_chnl_valid && dma_write_chnl_ready) begin
        beat_q.push_back(dma_write_chnl_data);
        beat_cyc_q.push_back(cyc);
      end
      if (write_done) done_cyc_q.push_back(cyc);
      if (stall_prev) begin
        stall_seen++;
        if (!dma_write_chnl_valid || dma_write_chnl_data != stall_data) stall_bad++;
      end
      stall_prev = dma_write_chnl_valid && !dma_write_chnl_ready;
      stall_data = dma_write_chnl_data;
      if (int'(dut.occ_q) > max_occ) max_occ = int'(dut.occ_q);
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; s is the cycle in which start is high.
  task automatic launch(input logic [ADDR_W-1:0] base, input logic [15:0] beats,
                        input logic [31:0] index, output int s);
    cfg_sram_base = base;
    cfg_beats     = beats;
    cfg_index     = index;
    start         = 1'b1;
    s             = cyc;
    tick(1);
    start = 1'b0;
  endtask

  // Run until a new write_done is logged. Mode 1 drives chnl_ready as
  // 1,0,0 repeating and injects a stray start pulse mid-transfer.
  task automatic wait_done(input int nd, input int limit, input int mode);
    int i;
    i = 0;
    while (done_cyc_q.size() <= nd && i < limit) begin
      if (mode == 1) begin
        dma_write_chnl_ready = (i % 3 == 0);
        if (i == 4) begin
          start         = 1'b1;
          cfg_beats     = 16'd3;
          cfg_sram_base = 16'h0700;
        end else begin
          start = 1'b0;
        end
      end
      tick(1);
      i++;
    end
    start                = 1'b0;
    dma_write_chnl_ready = 1'b1;
    check("done_seen", done_cyc_q.size() > nd, 1);
  endtask

  task automatic check_beats(input string tag, input int nb, input logic [ADDR_W-1:0] base,
                             input int n);
    check({tag, "_count"}, beat_q.size() - nb, n);
    for (int k = 0; k < n; k++) begin
      if (nb + k < beat_q.size()) check({tag, "_data"}, beat_q[nb + k], exp_beat(base, k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, nb, nh, nd, nc, i;

    rst                  = 1'b0;
    start                = 1'b0;
    cfg_index            = '0;
    cfg_beats            = '0;
    cfg_sram_base        = '0;
    dma_write_ctrl_ready = 1'b0;
    dma_write_chnl_ready = 1'b0;

    // Reset state.
    tick(2);
    @(negedge clk);
    check("rst_ctrl_valid", dma_write_ctrl_valid, 0);
    check("rst_chnl_valid", dma_write_chnl_valid, 0);
    check("rst_chnl_data", dma_write_chnl_data, 0);
    check("rst_done", write_done, 0);
    check("rst_size", dma_write_ctrl_data_size, 0);
    check("rst_addr0", sram_addr0, 0);
    tick(1);
    rst = 1'b1;
    tick(1);

    // Basic transfer: base 0, 4 beats, index 0x100, both readies high.
    dma_write_ctrl_ready = 1'b1;
    dma_write_chnl_ready = 1'b1;
    nb = beat_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
    launch(16'h0000, 16'd4, 32'h100, s);
    wait_done(nd, 60, 0);
    tick(3);
    check("a_hs_count", hs_cyc_q.size() - nh, 1);
    if (hs_cyc_q.size() > nh) begin
      check("a_hs_cycle", hs_cyc_q[nh], s + 1);
      check("a_index", hs_idx_q[nh], 32'h100);
      check("a_length", hs_len_q[nh], 32'd4);
      check("a_size", hs_size_q[nh], 3'b010);
      for (int k = 0; k < 4; k++) begin
        if (nb + k < beat_cyc_q.size()) check("a_beat_cycle", beat_cyc_q[nb + k], hs_cyc_q[nh] + 3 + k);
      end
    end
    check_beats("a_beats", nb, 16'h0000, 4);
    check("a_done_count", done_cyc_q.size() - nd, 1);
    if (done_cyc_q.size() > nd && beat_cyc_q.size() >= nb + 4)
      check("a_done_cycle", done_cyc_q[nd], beat_cyc_q[nb + 3] + 1);

    // Control stall: ready low for 5 cycles, fields stable, no SRAM reads.
    dma_write_ctrl_ready = 1'b0;
    nb = beat_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
    launch(16'h0040, 16'd1, 32'hABCD_0123, s);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("b_ctrl_valid", dma_write_ctrl_valid, 1);
      check("b_index", dma_write_ctrl_data_index, 32'hABCD_0123);
      check("b_length", dma_write_ctrl_data_length, 32'd1);
      check("b_size", dma_write_ctrl_data_size, 3'b010);
      check("b_addr0_idle", sram_addr0, 0);
      check("b_addr1_idle", sram_addr1, 0);
      tick(1);
    end
    dma_write_ctrl_ready = 1'b1;
    wait_done(nd, 40, 0);
    check("b_hs_count", hs_cyc_q.size() - nh, 1);
    if (hs_cyc_q.size() > nh) check("b_hs_cycle", hs_cyc_q[nh], s + 6);
    check_beats("b_beats", nb, 16'h0040, 1);

    // Channel back-pressure with 1,0,0 ready pattern and a stray start.
    nb = beat_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
    nc = stall_seen;
    launch(16'h0200, 16'd8, 32'h0000_0C00, s);
    wait_done(nd, 200, 1);
    tick(10);
    check("c_hs_count", hs_cyc_q.size() - nh, 1);
    check_beats("c_beats", nb, 16'h0200, 8);
    check("c_stalls_seen", stall_seen > nc, 1);
    check("c_done_count", done_cyc_q.size() - nd, 1);

    // Zero-length transfer.
    nb = beat_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
    nc = ctrl_valid_cycles;
    launch(16'h0300, 16'd0, 32'h0000_0D00, s);
    wait_done(nd, 10, 0);
    tick(2);
    if (done_cyc_q.size() > nd) check("d_done_cycle", done_cyc_q[nd], s + 1);
    check("d_ctrl_valid_cycles", ctrl_valid_cycles - nc, 0);
    check("d_hs_count", hs_cyc_q.size() - nh, 0);
    check("d_beat_count", beat_q.size() - nb, 0);

    // Reset after beat 2 of 8, then a fresh 2-beat transfer.
    nb = beat_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
    launch(16'h0000, 16'd8, 32'h0000_0E00, s);
    i = 0;
    while (beat_q.size() < nb + 2 && i < 50) begin
      tick(1);
      i++;
    end
    check("e_two_beats_seen", beat_q.size() - nb, 2);
    rst = 1'b0;
    tick(1);
    @(negedge clk);
    check("e_rst_ctrl_valid", dma_write_ctrl_valid, 0);
    check("e_rst_chnl_valid", dma_write_chnl_valid, 0);
    check("e_rst_chnl_data", dma_write_chnl_data, 0);
    check("e_rst_done", write_done, 0);
    check("e_rst_index", dma_write_ctrl_data_index, 0);
    check("e_rst_length", dma_write_ctrl_data_length, 0);
    check("e_rst_addr0", sram_addr0, 0);
    check("e_rst_addr1", sram_addr1, 0);
    tick(1);
    rst = 1'b1;
    nc = ctrl_valid_cycles;
    tick(6);
    check("e_idle_beats", beat_q.size() - nb, 2);
    check("e_idle_done", done_cyc_q.size() - nd, 0);
    check("e_idle_ctrl_valid", ctrl_valid_cycles - nc, 0);
    nb = beat_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
    launch(16'h0010, 16'd2, 32'h0000_0F00, s);
    wait_done(nd, 40, 0);
    check("e_new_hs_count", hs_cyc_q.size() - nh, 1);
    if (hs_cyc_q.size() > nh) check("e_new_length", hs_len_q[nh], 32'd2);
    check_beats("e_new_beats", nb, 16'h0010, 2);

    // Address wrap at the top of the SRAM.
    tick(2);
    nb = beat_q.size(); nd = done_cyc_q.size();
    launch(16'hFFFE, 16'd2, 32'h0000_0055, s);
    @(negedge clk);
    check("f_ctrl_addr0", sram_addr0, 16'h0000);
    tick(1);
    @(negedge clk);
    check("f_rd0_addr0", sram_addr0, 16'hFFFE);
    check("f_rd0_addr1", sram_addr1, 16'hFFFF);
    tick(1);
    @(negedge clk);
    check("f_rd1_addr0", sram_addr0, 16'h0000);
    check("f_rd1_addr1", sram_addr1, 16'h0001);
    tick(1);
    @(negedge clk);
    check("f_after_addr0", sram_addr0, 16'h0000);
    check("f_after_addr1", sram_addr1, 16'h0000);
    wait_done(nd, 40, 0);
    check_beats("f_beats", nb, 16'hFFFE, 2);

    tick(3);
    check("stall_data_held", stall_bad, 0);
    check("fifo_max_occ_le2", max_occ <= 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
